// File: rtl/weight_bank.sv
// Register bank of ROWS x COLS signed weights with row load, registered reads and an
// in-place delta-update sweep. Define WEIGHT_BANK_SATURATE_EN for saturating adds.
module weight_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ROWS  = 9,
  parameter int unsigned COLS  = 5,
  localparam int unsigned AW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned RW   = COLS * WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [RW-1:0] wr_data,
  input  logic          upd_start,
  input  logic          upd_valid,
  input  logic [RW-1:0] upd_delta,
  output logic          upd_ready,
  output logic          upd_busy,
  output logic          upd_done,
  output logic          sat_flag,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [RW-1:0] rd_data,
  output logic          rd_valid
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] mem [ROWS];
  logic [RW-1:0] cur_c;
  logic [RW-1:0] upd_row_c;
  logic [WIDTH-1:0] w_c, d_c;
  logic          beat_c;
  logic          wr_ok_c;

  assign beat_c  = (state == SWEEP) && upd_valid;
  assign wr_ok_c = (state == IDLE) && wr_en && (32'(wr_addr) < ROWS);
  assign cur_c   = mem[cnt];

  // Next-state and row counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (upd_start) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        if (upd_valid) begin
          if (cnt == AW'(ROWS - 1)) state_nxt = DONE;
          else                      cnt_nxt   = cnt + AW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; handshake outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      upd_ready <= 1'b0;
      upd_busy  <= 1'b0;
      upd_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      upd_ready <= (state_nxt == SWEEP);
      upd_busy  <= (state_nxt != IDLE);
      upd_done  <= (state_nxt == DONE);
    end
  end

`ifdef WEIGHT_BANK_SATURATE_EN
  logic [WIDTH:0] sum_c;
  logic           ovf_c;

  // Per-column add with one guard bit, clamped on signed overflow
  always_comb begin
    upd_row_c = '0;
    ovf_c     = 1'b0;
    w_c       = '0;
    d_c       = '0;
    sum_c     = '0;
    for (int c = 0; c < COLS; c++) begin
      w_c   = cur_c[c*WIDTH +: WIDTH];
      d_c   = upd_delta[c*WIDTH +: WIDTH];
      sum_c = {w_c[WIDTH-1], w_c} + {d_c[WIDTH-1], d_c};
      if (sum_c[WIDTH] != sum_c[WIDTH-1]) begin
        ovf_c = 1'b1;
        upd_row_c[c*WIDTH +: WIDTH] = sum_c[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                   : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        upd_row_c[c*WIDTH +: WIDTH] = sum_c[WIDTH-1:0];
      end
    end
  end

  // Sticky until the next sweep starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          sat_flag <= 1'b0;
    else if ((state == IDLE) && upd_start) sat_flag <= 1'b0;
    else if (beat_c && ovf_c)            sat_flag <= 1'b1;
  end
`else
  // Wrapping add: the guard bit is discarded, so add at WIDTH directly
  always_comb begin
    upd_row_c = '0;
    w_c       = '0;
    d_c       = '0;
    for (int c = 0; c < COLS; c++) begin
      w_c = cur_c[c*WIDTH +: WIDTH];
      d_c = upd_delta[c*WIDTH +: WIDTH];
      upd_row_c[c*WIDTH +: WIDTH] = w_c + d_c;
    end
  end

  assign sat_flag = 1'b0;
`endif

  // Weight storage: loads only in IDLE, delta beats only in SWEEP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else begin
      if (wr_ok_c) mem[wr_addr] <= wr_data;
      if (beat_c)  mem[cnt]     <= upd_row_c;
    end
  end

  // Registered read port; sees pre-update contents on a same-edge update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= (32'(rd_addr) < ROWS) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_weight_bank.sv
// Directed self-checking bench for weight_bank (WIDTH=16, ROWS=9, COLS=5).
module tb_weight_bank;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned ROWS  = 9;
  localparam int unsigned COLS  = 5;
  localparam int unsigned AW    = 4;
  localparam int unsigned RW    = 80;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [RW-1:0] wr_data = '0;
  logic          upd_start = 1'b0;
  logic          upd_valid = 1'b0;
  logic [RW-1:0] upd_delta = '0;
  logic          upd_ready, upd_busy, upd_done, sat_flag;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [RW-1:0] rd_data;
  logic          rd_valid;

  int total = 0;
  int bad   = 0;

  weight_bank #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .upd_start(upd_start), .upd_valid(upd_valid), .upd_delta(upd_delta),
    .upd_ready(upd_ready), .upd_busy(upd_busy), .upd_done(upd_done),
    .sat_flag(sat_flag),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] rep(input logic [WIDTH-1:0] v);
    return {COLS{v}};
  endfunction

  task automatic do_read(input logic [AW-1:0] a, output logic [RW-1:0] d, output logic v);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    d       = rd_data;
    v       = rd_valid;
    rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    logic [RW-1:0] d;
    logic v;
    rst_n = 1'b0;
    repeat (2) tick();
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", upd_ready); end
    total++; if (upd_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", upd_busy); end
    total++; if (upd_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", upd_done); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    rst_n = 1'b1;
    tick();
    for (int r = 0; r < ROWS; r++) begin
      do_read(AW'(r), d, v);
      total++;
      if (d !== '0 || v !== 1'b1) begin
        bad++; $display("FAIL reset_row%0d got=%h/%b exp=0/1", r, d, v);
      end
    end
  endtask

  task automatic test_write_read();
    logic [RW-1:0] d;
    logic v;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = rep(16'h0010);
    tick();
    wr_en = 1'b0;
    do_read(4'd3, d, v);
    total++; if (d !== rep(16'h0010)) begin bad++; $display("FAIL wr_rd_row3 got=%h exp=%h", d, rep(16'h0010)); end
    total++; if (v !== 1'b1) begin bad++; $display("FAIL wr_rd_valid got=%b exp=1", v); end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_idle_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== rep(16'h0010)) begin bad++; $display("FAIL rd_hold got=%h exp=%h", rd_data, rep(16'h0010)); end
    do_read(4'd4, d, v);
    total++; if (d !== '0) begin bad++; $display("FAIL wr_neighbour got=%h exp=0", d); end
  endtask

  task automatic test_sweep();
    logic [RW-1:0] d;
    logic v;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b exp=0", upd_ready); end
    end
    upd_start = 1'b1;
    tick();
    upd_start = 1'b0;
    total++; if (upd_busy !== 1'b1 || upd_ready !== 1'b1) begin bad++; $display("FAIL sweep_enter got=%b%b exp=11", upd_busy, upd_ready); end
    for (int r = 0; r < ROWS; r++) begin
      if (r == 4) begin
        upd_valid = 1'b0;
        upd_start = 1'b1;
        for (int s = 0; s < 3; s++) begin
          tick();
          total++;
          if (upd_ready !== 1'b1 || upd_done !== 1'b0) begin
            bad++; $display("FAIL stall%0d got=%b%b exp=10", s, upd_ready, upd_done);
          end
        end
        upd_start = 1'b0;
      end
      upd_valid = 1'b1;
      upd_delta = rep(16'h0001);
      tick();
      total++;
      if (r < ROWS - 1) begin
        if (upd_done !== 1'b0) begin bad++; $display("FAIL early_done beat%0d got=%b exp=0", r, upd_done); end
      end else begin
        if (upd_done !== 1'b1 || upd_ready !== 1'b0 || upd_busy !== 1'b1) begin
          bad++; $display("FAIL done_pulse got=%b%b%b exp=101", upd_done, upd_ready, upd_busy);
        end
      end
    end
    upd_valid = 1'b0;
    upd_delta = '0;
    tick();
    total++; if (upd_done !== 1'b0 || upd_busy !== 1'b0) begin bad++; $display("FAIL done_end got=%b%b exp=00", upd_done, upd_busy); end
    for (int r = 0; r < ROWS; r++) begin
      do_read(AW'(r), d, v);
      total++;
      if (d !== rep(16'h0001)) begin bad++; $display("FAIL sweep_row%0d got=%h exp=%h", r, d, rep(16'h0001)); end
    end
  endtask

  task automatic test_saturate();
    logic [RW-1:0] d;
    logic v;
    logic [15:0] e0, e1;
    logic e_sat;
`ifdef WEIGHT_BANK_SATURATE_EN
    e0 = 16'h7FFF; e1 = 16'h8000; e_sat = 1'b1;
`else
    e0 = 16'h8010; e1 = 16'h7FFF; e_sat = 1'b0;
`endif
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = {64'd0, 16'h8000};
    tick();
    wr_addr = 4'd0; wr_data = {64'd0, 16'h7FF0};
    upd_start = 1'b1;
    tick();
    wr_en = 1'b0; upd_start = 1'b0;
    total++; if (upd_busy !== 1'b1) begin bad++; $display("FAIL wr_start_busy got=%b exp=1", upd_busy); end
    for (int r = 0; r < ROWS; r++) begin
      upd_valid = 1'b1;
      upd_delta = (r == 0) ? {64'd0, 16'h0020} : (r == 1) ? {64'd0, 16'hFFFF} : '0;
      tick();
    end
    upd_valid = 1'b0;
    upd_delta = '0;
    tick();
    total++; if (sat_flag !== e_sat) begin bad++; $display("FAIL sat_flag got=%b exp=%b", sat_flag, e_sat); end
    do_read(4'd0, d, v);
    total++; if (d !== {64'd0, e0}) begin bad++; $display("FAIL sat_pos got=%h exp=%h", d, {64'd0, e0}); end
    do_read(4'd1, d, v);
    total++; if (d !== {64'd0, e1}) begin bad++; $display("FAIL sat_neg got=%h exp=%h", d, {64'd0, e1}); end
    do_read(4'd2, d, v);
    total++; if (d !== rep(16'h0001)) begin bad++; $display("FAIL sat_zero_delta got=%h exp=%h", d, rep(16'h0001)); end
  endtask

  task automatic test_same_edge_read();
    upd_start = 1'b1;
    tick();
    upd_start = 1'b0;
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_clear got=%b exp=0", sat_flag); end
    for (int r = 0; r < ROWS; r++) begin
      upd_valid = 1'b1;
      upd_delta = (r == 2) ? {64'd0, 16'h0004} : '0;
      rd_en     = (r == 2 || r == 3);
      rd_addr   = 4'd2;
      tick();
      if (r == 2) begin
        total++;
        if (rd_data[15:0] !== 16'h0001 || rd_valid !== 1'b1) begin
          bad++; $display("FAIL same_edge_old got=%h/%b exp=0001/1", rd_data[15:0], rd_valid);
        end
      end else if (r == 3) begin
        total++;
        if (rd_data[15:0] !== 16'h0005) begin
          bad++; $display("FAIL same_edge_new got=%h exp=0005", rd_data[15:0]);
        end
      end
    end
    rd_en = 1'b0;
    upd_valid = 1'b0;
    upd_delta = '0;
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    logic [RW-1:0] d;
    logic v;
    upd_start = 1'b1;
    tick();
    upd_start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      upd_valid = 1'b1;
      upd_delta = rep(16'h0001);
      tick();
    end
    upd_valid = 1'b0;
    upd_delta = '0;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = rep(16'hAAAA);
    tick();
    wr_en = 1'b0;
    do_read(4'd5, d, v);
    total++; if (d !== rep(16'h0001)) begin bad++; $display("FAIL sweep_wr_ignored got=%h exp=%h", d, rep(16'h0001)); end
    do_read(4'd3, d, v);
    total++; if (d !== rep(16'h0002)) begin bad++; $display("FAIL partial_row3 got=%h exp=%h", d, rep(16'h0002)); end
    do_read(4'd12, d, v);
    total++; if (d !== '0 || v !== 1'b1) begin bad++; $display("FAIL oob_read got=%h/%b exp=0/1", d, v); end
    total++; if (upd_busy !== 1'b1) begin bad++; $display("FAIL pre_reset_busy got=%b exp=1", upd_busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if (upd_busy !== 1'b0 || upd_ready !== 1'b0 || upd_done !== 1'b0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%b%b%b%b exp=0000", upd_busy, upd_ready, upd_done, rd_valid);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    upd_valid = 1'b1;
    upd_delta = rep(16'h0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (upd_done !== 1'b0 || upd_busy !== 1'b0) begin
        bad++; $display("FAIL post_reset_idle%0d got=%b%b exp=00", i, upd_done, upd_busy);
      end
    end
    upd_valid = 1'b0;
    upd_delta = '0;
    for (int r = 0; r < ROWS; r++) begin
      do_read(AW'(r), d, v);
      total++;
      if (d !== '0) begin bad++; $display("FAIL post_reset_row%0d got=%h exp=0", r, d); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_sweep();
    test_saturate();
    test_same_edge_read();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_bank.md
WEIGHT_BANK -- requirements
Module: weight_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bit width of one signed two's-complement weight.
REQ-002 SHALL have parameter ROWS, default 9, meaning number of weight rows (input neurons); AW = $clog2(ROWS).
REQ-003 SHALL have parameter COLS, default 5, meaning weights per row (output neurons); row bus width RW = COLS*WIDTH, column c at bits [c*WIDTH +: WIDTH].
REQ-004 SHALL have ports: clk  in  1  single clock, all state on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: wr_en  in  1  row load strobe; wr_addr  in  AW  load row; wr_data  in  RW  load value.
REQ-006 SHALL have ports: upd_start  in  1  begin update sweep; upd_valid  in  1  delta beat valid; upd_delta  in  RW  signed deltas for current row; upd_ready  out  1  beat accepted when high with upd_valid.
REQ-007 SHALL have ports: upd_busy  out  1  sweep in progress; upd_done  out  1  one-cycle sweep-complete pulse; sat_flag  out  1  sticky saturation indicator.
REQ-008 SHALL have ports: rd_en  in  1  read strobe; rd_addr  in  AW  read row; rd_data  out  RW  registered row; rd_valid  out  1  rd_data valid.

Function
REQ-009 SHALL hold ROWS x COLS weights in registers; no initialisation from files.
REQ-010 SHALL implement FSM IDLE, SWEEP, DONE with row counter cnt (AW bits).
REQ-011 SHALL in IDLE: upd_ready=0; upd_start=1 -> SWEEP, cnt=0, sat_flag cleared.
REQ-012 SHALL in SWEEP: upd_ready=1; on upd_valid&upd_ready add each column delta to row cnt; cnt==ROWS-1 -> DONE, else cnt+1; no beat -> stay, no change.
REQ-013 SHALL in DONE: assert upd_done for exactly one cycle, upd_ready=0, then -> IDLE.
REQ-014 SHALL drive upd_busy=1 in SWEEP and DONE, 0 in IDLE; upd_start outside IDLE ignored.
REQ-015 SHALL accept wr_en only in IDLE, overwriting row wr_addr with wr_data next edge; wr_en outside IDLE or wr_addr>=ROWS ignored.
REQ-016 SHALL, on wr_en and upd_start same IDLE cycle, perform the write and enter SWEEP; first delta applies to written value.
REQ-017 SHALL read with latency 1: rd_en at edge N -> rd_data/rd_valid at N+1; rd_valid=0 when rd_en was 0, rd_data holds last value.
REQ-018 SHALL return pre-update (old) row when reading the row updated on the same edge; rd_addr>=ROWS returns all zeros with rd_valid=1.
REQ-019 SHALL allow reads in every state, independent of update traffic.
REQ-020 SHALL compute each sum at WIDTH+1 bits then reduce to WIDTH per REQ-024/025.

Reset
REQ-021 SHALL on rst_n=0 asynchronously clear all weights, cnt, rd_data, rd_valid, upd_done, sat_flag to 0 and force IDLE (upd_ready=0, upd_busy=0).
REQ-022 SHALL abandon a sweep in progress on reset; rows already updated are cleared, no upd_done issued.
REQ-023 SHALL resume normal operation on first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with WEIGHT_BANK_SATURATE_EN defined, clamp overflowing sums to 2^(WIDTH-1)-1 or -2^(WIDTH-1) and set sat_flag (sticky until next upd_start or reset).
REQ-025 SHALL, without WEIGHT_BANK_SATURATE_EN, wrap sums modulo 2^WIDTH and tie sat_flag to 0.

Verification (WIDTH=16, ROWS=9, COLS=5)
REQ-026 SHALL cover: reset, wr_en row 3 = {5{16'h0010}}, rd_en addr 3 -> next cycle rd_data all 0x0010, rd_valid=1.
REQ-027 SHALL cover: all rows zero, upd_start, 9 beats of delta 0x0001, one beat withheld 3 cycles mid-sweep -> every weight 0x0001, upd_done one cycle after ninth beat, upd_ready low during stall-free IDLE.
REQ-028 SHALL cover: row 0 col 0 = 0x7FF0, delta 0x0020 -> macro on: 0x7FFF, sat_flag=1; macro off: 0x8010, sat_flag=0; -0x8000 + 0xFFFF clamps to 0x8000 with macro.
REQ-029 SHALL cover: read row 2 on same edge its delta 0x0004 accepted (old 0x0001) -> rd_data col 0 = 0x0001; next read 0x0005.
REQ-030 SHALL cover: rst_n low after 4 beats of sweep -> weights 0, upd_busy 0, no upd_done; wr_en during SWEEP ignored; rd_addr 12 returns 0.
